// File: rtl/seq_piso_serializer_if.sv
// Word-in / bit-out bus of the PISO serializer.
// Handshake: a word transfers on a rising edge where in_valid & in_ready; the serial side has no ready, a bit is taken every cycle out_valid=1.
interface seq_piso_serializer_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_bit;
  logic             out_first;
  logic             out_last;
  logic             busy;
  logic             dbg_state;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, out_bit, out_first, out_last, busy, dbg_state
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, out_bit, out_first, out_last, busy, dbg_state
  );
endinterface

// File: rtl/seq_piso_serializer.sv
// Parallel-in/serial-out stage with a one-word holding buffer so words stream gap-free.
// dbg_state reports the shifter FSM (0 idle, 1 active).
module seq_piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  seq_piso_serializer_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             hold_vld_q, hold_vld_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             active, done, acc;
  logic [WIDTH-1:0] sreg_shifted;

  assign active = (state_q == S_ACTIVE);
  assign done   = active && (cnt_q == LAST_CNT);
  assign acc    = bus.in_valid & ~hold_vld_q;

  // The bit on the output end is dropped; zeros fill from the other side.
  assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                  : {1'b0, sreg_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    if (active && !done) begin
      sreg_d = sreg_shifted;
      cnt_d  = cnt_q + CW'(1);
      if (acc) begin
        hold_data_d = bus.in_data;
        hold_vld_d  = 1'b1;
      end
    end else if (hold_vld_q) begin
      // Held word takes priority; in_ready is low so no new word can arrive.
      state_d    = S_ACTIVE;
      sreg_d     = hold_data_q;
      cnt_d      = '0;
      hold_vld_d = 1'b0;
    end else if (acc) begin
      state_d = S_ACTIVE;
      sreg_d  = bus.in_data;
      cnt_d   = '0;
    end else begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  assign bus.in_ready  = ~hold_vld_q;
  assign bus.out_valid = active;
  assign bus.out_bit   = active & (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
  assign bus.out_first = active & (cnt_q == '0);
  assign bus.out_last  = done;
  assign bus.busy      = active | hold_vld_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_seq_piso_serializer.sv
// Bench for seq_piso_serializer: MSB-first and LSB-first instances fed the same words,
// checked every cycle against a bit-queue model plus hand-computed literal streams.
module tb_seq_piso_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;

  int vectors = 0;
  int miscompares = 0;

  seq_piso_serializer_if #(.WIDTH(W)) if_m ();
  seq_piso_serializer_if #(.WIDTH(W)) if_l ();

  assign if_m.in_valid = in_valid;
  assign if_m.in_data  = in_data;
  assign if_l.in_valid = in_valid;
  assign if_l.in_data  = in_data;

  seq_piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(if_m.slave));
  seq_piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(if_l.slave));

  // clock
  always #5 clk = ~clk;

  // Model: every accepted word becomes W {first,last,bit} entries; one entry leaves per busy cycle.
  logic [2:0] exp_q_m[$];
  logic [2:0] exp_q_l[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q_m.delete();
      exp_q_l.delete();
    end else begin
      logic acc;
      acc = in_valid && (exp_q_m.size() <= W);
      if (exp_q_m.size() > 0) void'(exp_q_m.pop_front());
      if (exp_q_l.size() > 0) void'(exp_q_l.pop_front());
      if (acc) begin
        for (int i = 0; i < W; i++) begin
          exp_q_m.push_back({i == 0, i == W - 1, in_data[W-1-i]});
          exp_q_l.push_back({i == 0, i == W - 1, in_data[i]});
        end
      end
    end
  end

  // Downstream mod-3 detector on the MSB-first stream.
  int det_r;
  always @(posedge clk or posedge rst) begin
    if (rst) det_r <= 0;
    else if (if_m.out_valid) det_r <= (2 * det_r + int'(if_m.out_bit)) % 3;
  end

  // Length of the most recent unbroken out_valid run.
  int run_len = 0;
  int last_run = 0;
  always @(negedge clk) begin
    if (if_m.out_valid) run_len <= run_len + 1;
    else begin
      if (run_len > 0) last_run <= run_len;
      run_len <= 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input string tag, input logic v, input logic b, input logic f,
                          input logic l, input logic bz, input logic rdy,
                          input logic [2:0] head, input int size);
    logic ev;
    ev = (size > 0);
    chk({tag, ".out_valid"}, v, ev);
    chk({tag, ".out_bit"}, b, ev & head[0]);
    chk({tag, ".out_first"}, f, ev & head[2]);
    chk({tag, ".out_last"}, l, ev & head[1]);
    chk({tag, ".busy"}, bz, ev);
    chk({tag, ".in_ready"}, rdy, size <= W);
  endtask

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    logic [2:0] hm, hl;
    hm = (exp_q_m.size() > 0) ? exp_q_m[0] : 3'b000;
    hl = (exp_q_l.size() > 0) ? exp_q_l[0] : 3'b000;
    cmp_inst("m", if_m.out_valid, if_m.out_bit, if_m.out_first, if_m.out_last,
             if_m.busy, if_m.in_ready, hm, exp_q_m.size());
    cmp_inst("l", if_l.out_valid, if_l.out_bit, if_l.out_first, if_l.out_last,
             if_l.busy, if_l.in_ready, hl, exp_q_l.size());
  end

  // Driver: present a word from a falling edge until the rising edge that accepts it.
  task automatic send_word(input logic [W-1:0] w);
    logic rdy;
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 40; i++) begin
      rdy = if_m.in_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("send.accept", ok, 1);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom_range(0, 255);
  endtask

  // Gather one word's bits in emission order (first bit ends up in bit W-1).
  task automatic collect(output logic [W-1:0] sm, output logic [W-1:0] sl);
    sm = '0;
    sl = '0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("col.valid", if_m.out_valid, 1);
      chk("col.first", if_m.out_first, i == 0);
      chk("col.last", if_m.out_last, i == W - 1);
      sm = {sm[W-2:0], if_m.out_bit};
      sl = {sl[W-2:0], if_l.out_bit};
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64 && (if_m.busy || if_l.busy); i++) @(negedge clk);
    chk("idle.timeout", if_m.busy | if_l.busy, 0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] sm, sl;

    // reset
    repeat (2) @(negedge clk);
    #1;
    chk("rst.out_valid", if_m.out_valid, 0);
    chk("rst.in_ready", if_m.in_ready, 1);
    chk("rst.busy", if_l.busy, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: A5 from idle
    send_word(8'hA5);
    collect(sm, sl);
    chk("t1.stream_m", sm, 8'b1010_0101);
    chk("t1.stream_l", sl, 8'b1010_0101);
    @(negedge clk);
    chk("t1.after_valid", if_m.out_valid, 0);
    chk("t1.after_busy", if_m.busy, 0);

    // 2: back-to-back 03, 06, FF
    send_word(8'h03);
    send_word(8'h06);
    send_word(8'hFF);
    wait_idle();
    @(negedge clk);
    chk("t2.run_len", last_run, 24);

    // 3: 01 on both bit orders
    send_word(8'h01);
    collect(sm, sl);
    chk("t3.stream_l", sl, 8'b1000_0000);
    chk("t3.stream_m", sm, 8'b0000_0001);
    wait_idle();

    // 4: reset with FF mid-shift and 0F held
    send_word(8'hFF);
    send_word(8'h0F);
    @(negedge clk);
    @(negedge clk);
    chk("t4.pre_busy", if_m.busy, 1);
    chk("t4.pre_ready", if_m.in_ready, 0);
    chk("t4.pre_bit", if_m.out_bit, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t4.rst_valid", if_m.out_valid, 0);
    chk("t4.rst_bit", if_l.out_bit, 0);
    chk("t4.rst_ready", if_m.in_ready, 1);
    chk("t4.rst_busy", if_m.busy, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_word(8'h3C);
    collect(sm, sl);
    chk("t4.stream_m", sm, 8'h3C);
    chk("t4.stream_l", sl, 8'h3C);
    wait_idle();

    // 5: mod-3 detector fed from reset
    reset_pulse();
    send_word(8'h09);
    collect(sm, sl);
    @(negedge clk);
    chk("t5.success_09", det_r == 0, 1);
    reset_pulse();
    send_word(8'h0A);
    collect(sm, sl);
    @(negedge clk);
    chk("t5.success_0A", det_r == 0, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
